// File: rtl/psg_write_arbiter.sv
// psg_write_arbiter: arbitrates host and sequencer register writes into a FIFO
// and replays them onto the PSG's alternating address/data latch.
module psg_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_REG = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_valid,
    output logic       h_ready,
    input  logic [3:0] h_addr,
    input  logic [7:0] h_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_addr,
    input  logic [7:0] s_data,
    output logic [7:0] psg_data,
    output logic       wr_commit,
    output logic [2:0] fifo_level,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] FULL = 3'(FIFO_DEPTH);
    localparam logic [3:0] IDLE = 4'(IDLE_REG);

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ph_q, ph_d, active_q, active_d, prio_q, prio_d;
    logic          empty, space, push, pop;
    logic [11:0]   head, push_entry;

    // prio_q: 0 = host holds priority, 1 = sequencer
    always_comb begin
        empty      = cnt_q == 3'd0;
        space      = !reset && cnt_q < FULL;
        head       = mem_q[rd_q];
        h_ready    = space && h_valid && (!s_valid || !prio_q);
        s_ready    = space && s_valid && (!h_valid || prio_q);
        push       = h_ready || s_ready;
        push_entry = h_ready ? {h_addr, h_data} : {s_addr, s_data};
        pop        = !reset && !ph_q && active_q;
        wr_commit  = pop;
        psg_data   = reset ? 8'h00 :
                     ph_q  ? {4'h0, empty ? IDLE : head[11:8]} :
                     active_q ? head[7:0] : 8'h00;
        fifo_level = reset ? 3'd0 : cnt_q;
        busy       = fifo_level != 3'd0;
        ph_d       = !ph_q;
        // the issue decision is taken from occupancy at the start of the address phase
        active_d   = ph_q && !empty;
        prio_d     = push ? h_ready : prio_q;
        rd_d       = rd_q + AW'(pop);
        wr_d       = wr_q + AW'(push);
        cnt_d      = cnt_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q     <= 1'b0;
            active_q <= 1'b0;
            prio_q   <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= 3'd0;
        end else begin
            ph_q     <= ph_d;
            active_q <= active_d;
            prio_q   <= prio_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_entry;
    end
endmodule

// File: tb/tb_psg_write_arbiter.sv
// tb_psg_write_arbiter: scoreboard bench; accepted writes queue up and are checked at commit.
module tb_psg_write_arbiter;
    logic       clk = 1'b0, reset = 1'b1;
    logic       h_valid = 1'b0, s_valid = 1'b0;
    logic [3:0] h_addr = 4'h0, s_addr = 4'h0;
    logic [7:0] h_data = 8'h00, s_data = 8'h00;
    logic       h_ready, s_ready, wr_commit, busy;
    logic [7:0] psg_data;
    logic [2:0] fifo_level;

    int checks = 0, failures = 0;
    logic [11:0] sb[$];
    logic ph_m = 1'b0, act_m = 1'b0, prio_m = 1'b0;
    logic e_hr, e_sr, e_wc;
    logic [7:0] e_pd;
    int e_lvl, acc_m, com_o;
    logic o_hr, o_sr, o_wc, o_busy;
    logic [7:0] o_pd;
    logic [2:0] o_lvl;

    always #5 clk = ~clk;

    psg_write_arbiter dut (
        .clk(clk), .reset(reset),
        .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .psg_data(psg_data), .wr_commit(wr_commit), .fifo_level(fifo_level), .busy(busy)
    );

    // one clock: drive, predict, sample mid-cycle, then advance the model
    task automatic cycle(input logic hv, input logic [3:0] ha, input logic [7:0] hd,
                         input logic sv, input logic [3:0] sa, input logic [7:0] sd);
        h_valid = hv; h_addr = ha; h_data = hd;
        s_valid = sv; s_addr = sa; s_data = sd;
        e_lvl = sb.size();
        e_hr = hv && (!sv || !prio_m) && e_lvl < 4;
        e_sr = sv && (!hv || prio_m) && e_lvl < 4;
        e_wc = !ph_m && act_m;
        e_pd = ph_m ? (e_lvl != 0 ? {4'h0, sb[0][11:8]} : 8'h0F) : (act_m ? sb[0][7:0] : 8'h00);
        @(negedge clk);
        o_hr = h_ready; o_sr = s_ready; o_wc = wr_commit;
        o_pd = psg_data; o_lvl = fifo_level; o_busy = busy;
        if (o_wc) com_o++;
        @(posedge clk);
        if (e_wc) void'(sb.pop_front());
        if (e_hr) begin sb.push_back({ha, hd}); prio_m = 1'b1; acc_m++; end
        else if (e_sr) begin sb.push_back({sa, sd}); prio_m = 1'b0; acc_m++; end
        act_m = ph_m && e_lvl != 0;
        ph_m = !ph_m;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic model_reset();
        sb.delete();
        ph_m = 1'b0; act_m = 1'b0; prio_m = 1'b0;
    endtask

    task automatic align(input logic want_ph);
        for (int i = 0; i < 20 && (sb.size() != 0 || act_m || ph_m != want_ph); i++) idle();
        checks++;
        if (sb.size() != 0 || act_m || ph_m != want_ph) begin
            failures++; $display("FAIL align level=%0d active=%b ph=%b want_ph=%b", sb.size(), act_m, ph_m, want_ph);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; h_valid = 1'b1; s_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (h_ready !== 1'b0) begin failures++; $display("FAIL reset_h_ready got %b exp 0", h_ready); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        checks++; if (psg_data !== 8'h00) begin failures++; $display("FAIL reset_psg_data got %h exp 00", psg_data); end
        checks++; if (wr_commit !== 1'b0) begin failures++; $display("FAIL reset_wr_commit got %b exp 0", wr_commit); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_fifo_level got %0d exp 0", fifo_level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        reset = 1'b0; h_valid = 1'b0; s_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) begin
            idle();
            checks++; if (o_pd !== ((i % 2) ? 8'h0F : 8'h00)) begin failures++; $display("FAIL idle_psg_data cyc %0d got %h exp %h", i, o_pd, (i % 2) ? 8'h0F : 8'h00); end
            checks++; if (o_wc !== 1'b0) begin failures++; $display("FAIL idle_wr_commit cyc %0d got %b exp 0", i, o_wc); end
        end
    endtask

    task automatic test_single();
        align(1'b0);
        cycle(1'b1, 4'h7, 8'h38, 1'b0, 4'h0, 8'h00);
        checks++; if (o_hr !== 1'b1) begin failures++; $display("FAIL single_h_ready got %b exp 1", o_hr); end
        idle();
        checks++; if (o_pd !== 8'h07) begin failures++; $display("FAIL single_addr got %h exp 07", o_pd); end
        checks++; if (o_wc !== 1'b0) begin failures++; $display("FAIL single_addr_commit got %b exp 0", o_wc); end
        idle();
        checks++; if (o_pd !== 8'h38) begin failures++; $display("FAIL single_data got %h exp 38", o_pd); end
        checks++; if (o_wc !== 1'b1) begin failures++; $display("FAIL single_commit got %b exp 1", o_wc); end
        checks++; if (o_lvl !== 3'd1) begin failures++; $display("FAIL single_level_pre got %0d exp 1", o_lvl); end
        idle();
        checks++; if (o_lvl !== 3'd0) begin failures++; $display("FAIL single_level_post got %0d exp 0", o_lvl); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_ph1_push();
        align(1'b1);
        cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'hA5);
        checks++; if (o_pd !== 8'h0F) begin failures++; $display("FAIL ph1push_idle_addr got %h exp 0F", o_pd); end
        checks++; if (o_sr !== 1'b1) begin failures++; $display("FAIL ph1push_s_ready got %b exp 1", o_sr); end
        idle();
        checks++; if (o_wc !== 1'b0 || o_pd !== 8'h00) begin failures++; $display("FAIL ph1push_no_bypass got commit=%b data=%h exp 0/00", o_wc, o_pd); end
        idle();
        checks++; if (o_pd !== 8'h03) begin failures++; $display("FAIL ph1push_addr got %h exp 03", o_pd); end
        idle();
        checks++; if (o_wc !== 1'b1 || o_pd !== 8'hA5) begin failures++; $display("FAIL ph1push_data got commit=%b data=%h exp 1/A5", o_wc, o_pd); end
    endtask

    // both ports request every cycle: grant alternates, FIFO fills and stalls at 4
    task automatic test_back_to_back(input int n, input bit rnd);
        int full_seen;
        logic hv, sv;
        full_seen = 0; acc_m = 0; com_o = 0;
        for (int i = 0; i < n + 14; i++) begin
            hv = i < n && (!rnd || $urandom_range(0, 2) != 0);
            sv = i < n && (!rnd || $urandom_range(0, 2) != 0);
            cycle(hv, 4'(i), 8'(8'h10 + i), sv, 4'(~i), 8'(8'h80 + i));
            if (o_lvl == 3'd4) full_seen++;
            checks++; if (o_hr !== e_hr) begin failures++; $display("FAIL b2b_h_ready cyc %0d got %b exp %b", i, o_hr, e_hr); end
            checks++; if (o_sr !== e_sr) begin failures++; $display("FAIL b2b_s_ready cyc %0d got %b exp %b", i, o_sr, e_sr); end
            checks++; if (o_wc !== e_wc) begin failures++; $display("FAIL b2b_wr_commit cyc %0d got %b exp %b", i, o_wc, e_wc); end
            checks++; if (o_pd !== e_pd) begin failures++; $display("FAIL b2b_psg_data cyc %0d got %h exp %h", i, o_pd, e_pd); end
            checks++; if (32'(o_lvl) !== e_lvl) begin failures++; $display("FAIL b2b_fifo_level cyc %0d got %0d exp %0d", i, o_lvl, e_lvl); end
            checks++; if (o_busy !== (e_lvl != 0)) begin failures++; $display("FAIL b2b_busy cyc %0d got %b exp %b", i, o_busy, e_lvl != 0); end
        end
        checks++; if (com_o !== acc_m) begin failures++; $display("FAIL b2b_commit_count got %0d exp %0d", com_o, acc_m); end
        if (!rnd) begin
            checks++; if (full_seen < 2) begin failures++; $display("FAIL b2b_full_reached got %0d exp >=2", full_seen); end
        end
    endtask

    task automatic test_reset_mid();
        align(1'b0);
        cycle(1'b1, 4'h9, 8'h5C, 1'b0, 4'h0, 8'h00);
        idle();
        checks++; if (o_pd !== 8'h09) begin failures++; $display("FAIL rstmid_addr got %h exp 09", o_pd); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (wr_commit !== 1'b0) begin failures++; $display("FAIL rstmid_commit got %b exp 0", wr_commit); end
        checks++; if (psg_data !== 8'h00) begin failures++; $display("FAIL rstmid_psg_data got %h exp 00", psg_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        com_o = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++; if (o_lvl !== 3'd0) begin failures++; $display("FAIL rstmid_level cyc %0d got %0d exp 0", i, o_lvl); end
            checks++; if (o_pd !== ((i % 2) ? 8'h0F : 8'h00)) begin failures++; $display("FAIL rstmid_idle_data cyc %0d got %h exp %h", i, o_pd, (i % 2) ? 8'h0F : 8'h00); end
        end
        checks++; if (com_o !== 0) begin failures++; $display("FAIL rstmid_stray_commits got %0d exp 0", com_o); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_ph1_push();
        test_back_to_back(16, 1'b0);
        test_back_to_back(60, 1'b1);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psg_write_arbiter.md
PSG_WRITE_ARBITER -- requirements
Module: psg_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of queued write entries (power of two, >=2).
REQ-002 Parameter IDLE_REG, default 15, SHALL set the unused PSG register index driven during idle address phases.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, shared with the PSG core.
REQ-005 h_valid  input  1  host port write request.
REQ-006 h_ready  output  1  host request accepted this cycle.
REQ-007 h_addr  input  4  host target PSG register index.
REQ-008 h_data  input  8  host register value.
REQ-009 s_valid  input  1  sequencer port write request.
REQ-010 s_ready  output  1  sequencer request accepted this cycle.
REQ-011 s_addr  input  4  sequencer target PSG register index.
REQ-012 s_data  input  8  sequencer register value.
REQ-013 psg_data  output  8  byte driven to the PSG core's 8-bit data input.
REQ-014 wr_commit  output  1  high during the cycle whose data byte the PSG writes into a real register.
REQ-015 fifo_level  output  3  current occupancy, 0..FIFO_DEPTH.
REQ-016 busy  output  1  high when fifo_level != 0.

Function
REQ-017 Cycle 0 SHALL be the first cycle with reset low; phase register ph SHALL be 0 in cycle 0 and toggle every cycle (ph=0 data phase, ph=1 address phase), matching the PSG's alternating latch.
REQ-018 Accept rule: a port SHALL be accepted only when its valid is high, it holds the grant, and fifo_level < FIFO_DEPTH at cycle start; a pop in the same cycle SHALL NOT enable a push when full.
REQ-019 Grant: single requester wins; both valid -> priority pointer port wins; pointer SHALL move to the other port after each accepted push, and remain unchanged otherwise.
REQ-020 At most one push per cycle; accepted {addr,data} SHALL be appended at the FIFO tail at the rising edge.
REQ-021 ph=1: psg_data SHALL be {4'b0, head.addr} if FIFO non-empty, else {4'b0, IDLE_REG}; active flag SHALL register !empty at that edge.
REQ-022 ph=0: if active, psg_data SHALL be head.data, wr_commit SHALL be 1, and the head SHALL pop at the cycle's end edge; else psg_data SHALL be 8'h00, wr_commit 0, no pop.
REQ-023 The head entry SHALL be unchanged between its address phase and data phase; pushes in between SHALL not affect it.
REQ-024 Entry pushed in a ph=1 cycle into an empty FIFO SHALL not be issued until the next ph=1 cycle (two-cycle decision boundary, no bypass).
REQ-025 Simultaneous push and pop SHALL keep fifo_level constant; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Sustained throughput SHALL be one PSG register write per two cycles; writes SHALL commit in acceptance order.
REQ-027 h_ready, s_ready, psg_data, wr_commit SHALL be combinational from registered state and current valids only.

Reset
REQ-028 While reset is high: ph=0, active=0, FIFO empty, pointers 0, priority pointer=host; psg_data=8'h00, wr_commit=0, h_ready=s_ready=0, fifo_level=0, busy=0.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight writes with no partial commit after reset rises.

Verification
REQ-030 Idle after reset, no requests -> psg_data alternates 00 (ph0), 0F (ph1), wr_commit never high.
REQ-031 Host writes (addr 7, 0x38) in cycle 0 -> cycle 1 psg_data=0x07, cycle 2 psg_data=0x38, wr_commit=1, fifo_level returns to 0 after cycle 2.
REQ-032 Both ports valid every cycle, FIFO empty -> accepts alternate host, seq, host...; writes commit in that order, one per two cycles.
REQ-033 Fill 4 entries, both valid -> h_ready=s_ready=0 while fifo_level=4, including the pop cycle; push resumes the next cycle.
REQ-034 Push in a ph=1 cycle into empty FIFO -> idle address 0x0F that cycle, entry address on the next ph=1 cycle.
REQ-035 Assert reset in the ph=0 cycle of a pending write -> wr_commit=0 from that cycle, fifo_level=0, psg_data=00 afterwards.
